// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: the keypad geometry, the scan
// state encoding and two small helpers for one-hot row/column vectors.
package keypad_pkg;

  // The keypad is a square 4x4 matrix; rows and columns share one width.
  localparam int KEY_W = 4;

  // Row that is driven first after reset.
  localparam logic [KEY_W-1:0] ROW0_ONEHOT = 4'b0001;

  // Scanner states. SCAN walks the rows; the two debounce states qualify a
  // press or a release; HELD waits for the accepted key to be let go.
  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } scan_state_e;

  // True when exactly one bit is set. Zero or several closed contacts are
  // treated as "no usable key" by the scanner.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  // Next row in the scan order 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  function automatic logic [KEY_W-1:0] rotate_row(input logic [KEY_W-1:0] v);
    return {v[KEY_W-2:0], v[KEY_W-1]};
  endfunction

endpackage

// File: rtl/keypad_scanner_synchronizer.sv
// Two-flop synchronizer for asynchronous keypad lines. Each bit is
// synchronized independently; the scanner only ever consumes the output
// flop, so metastability on the first stage has a full cycle to settle.
module keypad_scanner_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back capture stages, cleared to "no key" on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Drives the rows one at a time, samples the synchronized columns at the end
// of each row's dwell, debounces a single key press and release, and hands
// the decoder a stable one-hot row/column pair with a one-cycle strobe.
// Build option: define KEYPAD_ACTIVE_LOW_EN for pull-up keypad wiring; the
// row drive and column sense then become active-low at the pins, while
// key_rows/key_cols stay active-high.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1200,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] cols_in,
  output logic [KEY_W-1:0] rows_out,
  output logic [KEY_W-1:0] key_rows,
  output logic [KEY_W-1:0] key_cols,
  output logic             key_valid,
  output logic             key_held
);

  // One counter width serves both the row dwell and the debounce count.
  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                              : DEBOUNCE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_e      state, state_next;
  logic [KEY_W-1:0] row_q, row_next;
  logic [CNT_W-1:0] scan_cnt, scan_cnt_next;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_next;
  logic [KEY_W-1:0] cand_row, cand_row_next;
  logic [KEY_W-1:0] cand_col, cand_col_next;
  logic [KEY_W-1:0] key_rows_next, key_cols_next;
  logic             key_valid_next;

  logic [KEY_W-1:0] cols_active;
  logic [KEY_W-1:0] cols_sync;
  logic             cand_hit;

`ifdef KEYPAD_ACTIVE_LOW_EN
  // Pull-up wiring: a closed contact pulls the column low, and the selected
  // row is the one driven low. Internally everything stays active-high.
  assign cols_active = ~cols_in;
  assign rows_out    = ~row_q;
`else
  assign cols_active = cols_in;
  assign rows_out    = row_q;
`endif

  keypad_scanner_synchronizer #(
    .WIDTH(KEY_W)
  ) u_cols_sync (
    .clk  (clk),
    .reset(reset),
    .d    (cols_active),
    .q    (cols_sync)
  );

  // While a key is held only its own column matters; other contacts in the
  // frozen row are deliberately ignored.
  assign cand_hit = |(cols_sync & cand_col);

  // The key is reported as held from acceptance until the release debounce
  // completes, so a release glitch never drops key_held.
  assign key_held = (state == HELD) || (state == DEBOUNCE_RELEASE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN;
    end else begin
      state <= state_next;
    end
  end

  // Row drive, counters, candidate key and the registered decoder outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q     <= ROW0_ONEHOT;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      key_rows  <= '0;
      key_cols  <= '0;
      key_valid <= 1'b0;
    end else begin
      row_q     <= row_next;
      scan_cnt  <= scan_cnt_next;
      deb_cnt   <= deb_cnt_next;
      cand_row  <= cand_row_next;
      cand_col  <= cand_col_next;
      key_rows  <= key_rows_next;
      key_cols  <= key_cols_next;
      key_valid <= key_valid_next;
    end
  end

  // Next-state and datapath decisions. Counters only increment below their
  // terminal value, so they can never wrap.
  always_comb begin
    state_next     = state;
    row_next       = row_q;
    scan_cnt_next  = scan_cnt;
    deb_cnt_next   = deb_cnt;
    cand_row_next  = cand_row;
    cand_col_next  = cand_col;
    key_rows_next  = key_rows;
    key_cols_next  = key_cols;
    key_valid_next = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_next = '0;
          if (is_onehot(cols_sync)) begin
            cand_row_next = row_q;
            cand_col_next = cols_sync;
            deb_cnt_next  = '0;
            state_next    = DEBOUNCE_PRESS;
          end else begin
            row_next = rotate_row(row_q);
          end
        end else begin
          scan_cnt_next = scan_cnt + CNT_W'(1);
        end
      end

      DEBOUNCE_PRESS: begin
        if (cols_sync == cand_col) begin
          if (deb_cnt == DEB_LAST) begin
            deb_cnt_next   = '0;
            key_valid_next = 1'b1;
            key_rows_next  = cand_row;
            key_cols_next  = cand_col;
            state_next     = HELD;
          end else begin
            deb_cnt_next = deb_cnt + CNT_W'(1);
          end
        end else begin
          deb_cnt_next  = '0;
          scan_cnt_next = '0;
          row_next      = rotate_row(row_q);
          state_next    = SCAN;
        end
      end

      HELD: begin
        if (!cand_hit) begin
          deb_cnt_next = '0;
          state_next   = DEBOUNCE_RELEASE;
        end
      end

      DEBOUNCE_RELEASE: begin
        if (cand_hit) begin
          deb_cnt_next = '0;
          state_next   = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          deb_cnt_next  = '0;
          scan_cnt_next = '0;
          row_next      = rotate_row(row_q);
          state_next    = SCAN;
        end else begin
          deb_cnt_next = deb_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A physical keypad model (which keys
// are pressed, and which row is being driven) produces cols_in; expected
// outputs come from timing arithmetic on scan dwell and debounce length.
// Honours KEYPAD_ACTIVE_LOW_EN for the pin polarity of rows_out/cols_in.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols_in;
  logic [3:0] rows_out;
  logic [3:0] key_rows;
  logic [3:0] key_cols;
  logic       key_valid;
  logic       key_held;

  int total = 0;
  int bad   = 0;
  int now   = 0;

  logic [3:0] pressed [4];
  bit         glitch;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols_in  (cols_in),
    .rows_out (rows_out),
    .key_rows (key_rows),
    .key_cols (key_cols),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Pin-level polarity of the keypad wiring.
  function automatic logic [3:0] pad(input logic [3:0] v);
`ifdef KEYPAD_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << (i % 4);
  endfunction

  // Row being driven t cycles after reset when no key has been accepted.
  function automatic logic [3:0] idle_row(input int t);
    return onehot((t / SCAN) % 4);
  endfunction

  // Keypad model: a pressed key closes its column only while its row is driven.
  task automatic drive_cols();
    logic [3:0] act;
    logic [3:0] c;
    act = pad(rows_out);
    c   = 4'b0000;
    for (int i = 0; i < 4; i++) if (act[i]) c = c | pressed[i];
    if (glitch) c = 4'b0000;
    cols_in = pad(c);
  endtask

  task automatic step();
    @(negedge clk);
    now++;
    drive_cols();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    glitch = 1'b0;
    for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;
    cols_in = pad(4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    now   = 0;
    drive_cols();
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    do_reset();
    total++; if (rows_out !== pad(4'b0001)) begin bad++; $display("FAIL reset_rows got=%b want=%b", rows_out, pad(4'b0001)); end
    total++; if (key_rows !== 4'b0000) begin bad++; $display("FAIL reset_key_rows got=%b want=0000", key_rows); end
    total++; if (key_cols !== 4'b0000) begin bad++; $display("FAIL reset_key_cols got=%b want=0000", key_cols); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", key_held); end
    for (int i = 0; i < 40; i++) begin
      exp_row = pad(idle_row(now));
      total++; if (rows_out !== exp_row) begin bad++; $display("FAIL idle_rows t=%0d got=%b want=%b", now, rows_out, exp_row); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid t=%0d got=%b want=0", now, key_valid); end
      step();
    end
  endtask

  task automatic test_clean_press();
    int r, vt;
    logic [3:0] c, exp_row;
    logic exp_v, exp_h;
    r = $urandom_range(0, 3);
    c = onehot($urandom_range(0, 3));
    do_reset();
    pressed[r] = c;
    drive_cols();
    vt = SCAN * (r + 1) + DEB;
    while (now <= vt + 20) begin
      exp_row = pad((now < SCAN * r) ? idle_row(now) : onehot(r));
      exp_v   = (now == vt);
      exp_h   = (now >= vt);
      total++; if (rows_out !== exp_row) begin bad++; $display("FAIL press_rows t=%0d got=%b want=%b", now, rows_out, exp_row); end
      total++; if (key_valid !== exp_v) begin bad++; $display("FAIL press_valid t=%0d got=%b want=%b", now, key_valid, exp_v); end
      total++; if (key_held !== exp_h) begin bad++; $display("FAIL press_held t=%0d got=%b want=%b", now, key_held, exp_h); end
      step();
    end
    total++; if (key_rows !== onehot(r)) begin bad++; $display("FAIL press_key_rows got=%b want=%b", key_rows, onehot(r)); end
    total++; if (key_cols !== c) begin bad++; $display("FAIL press_key_cols got=%b want=%b", key_cols, c); end
  endtask

  task automatic test_bounce_press();
    int r, p, rv;
    logic [3:0] c;
    logic exp_v;
    r = $urandom_range(0, 3);
    c = onehot($urandom_range(0, 3));
    do_reset();
    pressed[r] = c;
    drive_cols();
    p = SCAN * (r + 1);
    while (now < p + 2) step();
    glitch = 1'b1;
    drive_cols();
    glitch = 1'b0;
    step();
    step();
    total++; if (rows_out !== pad(onehot(r))) begin bad++; $display("FAIL bounce_frozen got=%b want=%b", rows_out, pad(onehot(r))); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL bounce_valid_early got=%b want=0", key_valid); end
    step();
    total++; if (rows_out !== pad(onehot(r + 1))) begin bad++; $display("FAIL bounce_next_row got=%b want=%b", rows_out, pad(onehot(r + 1))); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held got=%b want=0", key_held); end
    // The key is still down, so it is picked up again on the next visit.
    rv = now + 3 * SCAN + SCAN + DEB;
    while (now <= rv + 2) begin
      exp_v = (now == rv);
      total++; if (key_valid !== exp_v) begin bad++; $display("FAIL bounce_revisit t=%0d got=%b want=%b", now, key_valid, exp_v); end
      step();
    end
    total++; if (key_rows !== onehot(r)) begin bad++; $display("FAIL bounce_key_rows got=%b want=%b", key_rows, onehot(r)); end
  endtask

  task automatic test_multi_key();
    int r, vt;
    logic [3:0] m, exp_row;
    r = $urandom_range(0, 3);
    do m = 4'($urandom_range(0, 15)); while ($countones(m) < 2);
    do_reset();
    pressed[r] = m;
    drive_cols();
    for (int i = 0; i < 40; i++) begin
      exp_row = pad(idle_row(now));
      total++; if (rows_out !== exp_row) begin bad++; $display("FAIL multi_rows t=%0d got=%b want=%b", now, rows_out, exp_row); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_valid t=%0d got=%b want=0", now, key_valid); end
      step();
    end
    r = $urandom_range(0, 3);
    do_reset();
    pressed[r] = 4'b0001;
    drive_cols();
    vt = SCAN * (r + 1) + DEB;
    while (now < vt) step();
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL multi_accept got=%b want=1", key_valid); end
    pressed[r] = 4'b0101;
    pressed[(r + 1) % 4] = onehot($urandom_range(0, 3));
    drive_cols();
    for (int i = 0; i < 30; i++) begin
      step();
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_extra_valid t=%0d got=%b want=0", now, key_valid); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL multi_extra_held t=%0d got=%b want=1", now, key_held); end
    end
    total++; if (key_cols !== 4'b0001) begin bad++; $display("FAIL multi_key_cols got=%b want=0001", key_cols); end
    total++; if (rows_out !== pad(onehot(r))) begin bad++; $display("FAIL multi_frozen got=%b want=%b", rows_out, pad(onehot(r))); end
  endtask

  task automatic test_release();
    int r, vt, len, kr, fall;
    logic [3:0] c, exp_row;
    logic exp_h;
    r = $urandom_range(0, 3);
    c = onehot($urandom_range(0, 3));
    do_reset();
    pressed[r] = c;
    drive_cols();
    vt = SCAN * (r + 1) + DEB;
    while (now < vt) step();
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL release_accept got=%b want=1", key_valid); end
    // Short release glitch, shorter than the debounce window.
    len = $urandom_range(1, 6);
    pressed[r] = 4'b0000;
    drive_cols();
    repeat (len) step();
    pressed[r] = c;
    drive_cols();
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held t=%0d got=%b want=1", now, key_held); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid t=%0d got=%b want=0", now, key_valid); end
    end
    // Clean release: 2 sync + 1 detection + DEB debounce cycles.
    kr = now;
    pressed[r] = 4'b0000;
    drive_cols();
    fall = kr + 3 + DEB;
    while (now < fall + SCAN + 1) begin
      step();
      exp_h   = (now < fall);
      exp_row = pad((now < fall) ? onehot(r) : ((now < fall + SCAN) ? onehot(r + 1) : onehot(r + 2)));
      total++; if (key_held !== exp_h) begin bad++; $display("FAIL release_held t=%0d got=%b want=%b", now, key_held, exp_h); end
      total++; if (rows_out !== exp_row) begin bad++; $display("FAIL release_rows t=%0d got=%b want=%b", now, rows_out, exp_row); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL release_valid t=%0d got=%b want=0", now, key_valid); end
    end
    total++; if (key_rows !== onehot(r)) begin bad++; $display("FAIL release_keep_rows got=%b want=%b", key_rows, onehot(r)); end
    total++; if (key_cols !== c) begin bad++; $display("FAIL release_keep_cols got=%b want=%b", key_cols, c); end
  endtask

  task automatic test_reset_mid();
    int ra, rb, vt, kr, fall;
    logic [3:0] ca, cb;
    logic exp_v;
    ra = $urandom_range(0, 3);
    ca = onehot($urandom_range(0, 3));
    do_reset();
    pressed[ra] = ca;
    drive_cols();
    vt = SCAN * (ra + 1) + DEB;
    while (now < vt) step();
    pressed[ra] = 4'b0000;
    drive_cols();
    kr   = now;
    fall = kr + 3 + DEB;
    while (now < fall) step();
    rb = (ra + 1) % 4;
    cb = onehot($urandom_range(0, 3));
    pressed[rb] = cb;
    drive_cols();
    while (now < fall + SCAN + 3) step();
    total++; if (key_rows !== onehot(ra)) begin bad++; $display("FAIL mid_pre_rows got=%b want=%b", key_rows, onehot(ra)); end
    #2 reset = 1'b1;
    #1;
    total++; if (rows_out !== pad(4'b0001)) begin bad++; $display("FAIL mid_rst_rows got=%b want=%b", rows_out, pad(4'b0001)); end
    total++; if (key_rows !== 4'b0000) begin bad++; $display("FAIL mid_rst_key_rows got=%b want=0000", key_rows); end
    total++; if (key_cols !== 4'b0000) begin bad++; $display("FAIL mid_rst_key_cols got=%b want=0000", key_cols); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_rst_held got=%b want=0", key_held); end
    @(negedge clk);
    reset = 1'b0;
    now   = 0;
    drive_cols();
    vt = SCAN * (rb + 1) + DEB;
    while (now <= vt + 2) begin
      exp_v = (now == vt);
      total++; if (key_valid !== exp_v) begin bad++; $display("FAIL mid_restart t=%0d got=%b want=%b", now, key_valid, exp_v); end
      step();
    end
    total++; if (key_cols !== cb) begin bad++; $display("FAIL mid_restart_cols got=%b want=%b", key_cols, cb); end
  endtask

  task automatic test_polarity();
    int vt;
    do_reset();
    total++; if (rows_out !== pad(4'b0001)) begin bad++; $display("FAIL pol_reset_rows got=%b want=%b", rows_out, pad(4'b0001)); end
    pressed[2] = 4'b0010;
    drive_cols();
    while (now < 2 * SCAN) step();
    total++; if (rows_out !== pad(4'b0100)) begin bad++; $display("FAIL pol_rows got=%b want=%b", rows_out, pad(4'b0100)); end
    vt = 3 * SCAN + DEB;
    while (now < vt) step();
    total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL pol_valid got=%b want=1", key_valid); end
    total++; if (key_rows !== 4'b0100) begin bad++; $display("FAIL pol_key_rows got=%b want=0100", key_rows); end
    total++; if (key_cols !== 4'b0010) begin bad++; $display("FAIL pol_key_cols got=%b want=0010", key_cols); end
    total++; if (rows_out !== pad(4'b0100)) begin bad++; $display("FAIL pol_frozen got=%b want=%b", rows_out, pad(4'b0100)); end
  endtask

  initial begin
    reset   = 1'b1;
    glitch  = 1'b0;
    for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;
    cols_in = pad(4'b0000);
    repeat (2) @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_multi_key();
    test_release();
    test_reset_mid();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
